// File: rtl/bus_ecc_strip.sv
// Registered SEC Hamming(71,64) strip stage: LANES codewords in, LANES x 64-bit payload out after one clock.
// Define ECC_STRIP_CORRECT_EN to flip the erroneous bit; otherwise single errors are only flagged.
module eccLaneDec (
  input  logic [70:0] cw,
  output logic [63:0] data,
  output logic        corr,
  output logic        unc
);
  logic [6:0]  syn;
  logic [70:0] fixed;

  // Bit index of data bit d: d-th non-power-of-two Hamming position, minus one.
  function automatic int posOf(input int d);
    int n;
    n = 0;
    for (int p = 1; p <= 71; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == d) return p - 1;
        n++;
      end
    end
    return 0;
  endfunction

  always_comb begin
    syn = '0;
    for (int i = 0; i < 71; i++)
      if (cw[i]) syn ^= 7'(i + 1);
  end

  assign corr = (syn != '0) && (syn <= 7'd71);
  assign unc  = syn > 7'd71;

`ifdef ECC_STRIP_CORRECT_EN
  always_comb begin
    fixed = cw;
    for (int i = 0; i < 71; i++)
      if (corr && syn == 7'(i + 1)) fixed[i] = ~cw[i];
  end
`else
  assign fixed = cw;
`endif

  for (genvar d = 0; d < 64; d++) begin : gExt
    assign data[d] = fixed[posOf(d)];
  end
endmodule

module bus_ecc_strip #(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_en,
  input  logic [LANES*71-1:0]   in_data,
  output logic                  out_en,
  output logic [LANES*64-1:0]   out_data,
  output logic [LANES-1:0]      out_corr,
  output logic [LANES-1:0]      out_unc,
  output logic [CNT_W-1:0]      err_cnt
);
  localparam int STAGES = 1;
  localparam int PW     = $clog2(LANES + 1);
  localparam logic [CNT_W+PW-1:0] CMAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

  logic [LANES-1:0][70:0] cw;
  logic [LANES-1:0][63:0] decData;
  logic [LANES-1:0]       decCorr, decUnc;
  logic [STAGES:0]        vldPipe;
  logic [PW-1:0]          pop;
  logic [CNT_W+PW-1:0]    sum;

  assign cw = in_data;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    eccLaneDec uDec (.cw(cw[g]), .data(decData[g]), .corr(decCorr[g]), .unc(decUnc[g]));
  end

  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) pop += PW'(decCorr[l]);
  end

  // Widened add so a large per-cycle popcount can never wrap past the clamp.
  assign sum = {{PW{1'b0}}, err_cnt} + {{CNT_W{1'b0}}, pop};

  assign vldPipe[0] = in_en;
  assign out_en     = vldPipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vldPipe[STAGES:1] <= '0;
      out_data          <= '0;
      out_corr          <= '0;
      out_unc           <= '0;
      err_cnt           <= '0;
    end else begin
      vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
      if (in_en) begin
        out_data <= decData;
        out_corr <= decCorr;
        out_unc  <= decUnc;
        err_cnt  <= (sum > CMAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end else begin
        out_corr <= '0;
        out_unc  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_ecc_strip.sv
// Bench for bus_ecc_strip: model predicts outputs from the injected flip pattern, plus literal checks.
module tb_bus_ecc_strip;
  localparam int L = 8;

  logic clk = 0, rst = 1, in_en = 0;
  logic [L*71-1:0] in_data = '0;
  logic            out_en, out_en2;
  logic [L*64-1:0] out_data, out_data2;
  logic [L-1:0]    out_corr, out_unc, out_corr2, out_unc2;
  logic [15:0]     err_cnt;
  logic [1:0]      err_cnt2;

  bus_ecc_strip #(.LANES(L), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .out_en(out_en),
    .out_data(out_data), .out_corr(out_corr), .out_unc(out_unc), .err_cnt(err_cnt));
  bus_ecc_strip #(.LANES(L), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .out_en(out_en2),
    .out_data(out_data2), .out_corr(out_corr2), .out_unc(out_unc2), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  bit chkOn = 0;

  logic [63:0] stimData [L];
  logic [70:0] stimMask [L];
  logic [L*64-1:0] pendData, expData;
  logic [L-1:0]    pendCorr, pendUnc, expCorr, expUnc;
  logic            expEn;
  int              expCnt, expCnt2;

  function automatic logic [70:0] encode(input logic [63:0] d);
    logic [70:0] w; logic [6:0] s; int j;
    w = '0; s = '0; j = 0;
    for (int p = 1; p <= 71; p++)
      if ((p & (p - 1)) != 0) begin
        w[p-1] = d[j];
        if (d[j]) s ^= 7'(p);
        j++;
      end
    for (int k = 0; k < 7; k++) w[(1 << k) - 1] = s[k];
    return w;
  endfunction

  // Data bit index held at Hamming position p, or -1 for a check position.
  function automatic int dataIdx(input int p);
    int np;
    if ((p & (p - 1)) == 0) return -1;
    np = 0;
    for (int k = 0; k < 7; k++) if ((1 << k) <= p) np++;
    return p - 1 - np;
  endfunction

  task automatic chk(input string nm, input logic [L*64-1:0] act, input logic [L*64-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; expectations come from data + flip masks only.
  task automatic apply(input logic en);
    int s, idx;
    logic [63:0] d;
    @(negedge clk); #1;
    for (int l = 0; l < L; l++) begin
      in_data[71*l +: 71] = encode(stimData[l]) ^ stimMask[l];
      s = 0; d = stimData[l];
      for (int i = 0; i < 71; i++)
        if (stimMask[l][i]) begin
          s ^= i + 1;
          idx = dataIdx(i + 1);
          if (idx >= 0) d[idx] = ~d[idx];
        end
      pendCorr[l] = (s != 0) && (s <= 71);
      pendUnc[l]  = s > 71;
`ifdef ECC_STRIP_CORRECT_EN
      if (pendCorr[l]) begin
        idx = dataIdx(s);
        if (idx >= 0) d[idx] = ~d[idx];
      end
`endif
      pendData[64*l +: 64] = d;
    end
    in_en = en;
    @(posedge clk); #1;
    in_en = 0;
  endtask

  task automatic clearStim();
    for (int l = 0; l < L; l++) begin stimData[l] = '0; stimMask[l] = '0; end
  endtask

  task automatic doReset();
    @(negedge clk); #1; rst = 1; in_en = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      expEn = 0; expData = '0; expCorr = '0; expUnc = '0; expCnt = 0; expCnt2 = 0;
    end else if (in_en) begin
      expEn = 1; expData = pendData; expCorr = pendCorr; expUnc = pendUnc;
      expCnt  += $countones(pendCorr); if (expCnt > 65535) expCnt = 65535;
      expCnt2 += $countones(pendCorr); if (expCnt2 > 3) expCnt2 = 3;
    end else begin
      expEn = 0; expCorr = '0; expUnc = '0;
    end
  end

  always @(negedge clk) if (chkOn) begin
    chk("en",   512'(out_en),   512'(expEn));
    chk("data", out_data,       expData);
    chk("corr", 512'(out_corr), 512'(expCorr));
    chk("unc",  512'(out_unc),  512'(expUnc));
    chk("cnt",  512'(err_cnt),  512'(expCnt));
    chk("cnt2", 512'(err_cnt2), 512'(expCnt2));
    chk("data2", out_data2,     expData);
  end

  initial begin
    int ln, b1, b2;
    clearStim();
    doReset();
    @(negedge clk);
    chk("rst_en", 512'(out_en), 512'(0));
    chk("rst_data", out_data, '0);
    chk("rst_flags", 512'({out_corr, out_unc}), 512'(0));
    chk("rst_cnt", 512'(err_cnt), 512'(0));
    chkOn = 1;

    apply(1);
    chk("zero_en", 512'(out_en), 512'(1));
    chk("zero_data", out_data, '0);
    chk("zero_flags", 512'({out_corr, out_unc}), 512'(0));

    stimData[0] = 64'h0123_4567_89AB_CDEF; stimMask[0][2] = 1'b1;
    apply(1);
`ifdef ECC_STRIP_CORRECT_EN
    chk("t3_lane0", 512'(out_data[63:0]), 512'(64'h0123_4567_89AB_CDEF));
`else
    chk("t3_lane0", 512'(out_data[63:0]), 512'(64'h0123_4567_89AB_CDEE));
`endif
    chk("t3_corr", 512'(out_corr), 512'(8'h01));
    chk("t3_cnt", 512'(err_cnt), 512'(1));

    clearStim();
    stimData[3] = 64'hDEAD_BEEF_CAFE_F00D; stimMask[3][63] = 1'b1;
    apply(1);
    chk("t4_lane3", 512'(out_data[255:192]), 512'(64'hDEAD_BEEF_CAFE_F00D));
    chk("t4_corr", 512'(out_corr), 512'(8'h08));
    chk("t4_unc", 512'(out_unc), 512'(0));

    clearStim();
    stimData[5] = 64'h5555_AAAA_0F0F_F0F0;
    foreach (stimMask[5][i]) if (i inside {0, 1, 3, 7, 15, 31, 63}) stimMask[5][i] = 1'b1;
    apply(1);
    chk("t5_unc", 512'(out_unc), 512'(8'h20));
    chk("t5_corr", 512'(out_corr), 512'(0));
    chk("t5_cnt", 512'(err_cnt), 512'(2));
    chk("t5_lane5", 512'(out_data[383:320]), 512'(64'h5555_AAAA_0F0F_F0F0));

    // idle cycle: data must hold, flags clear
    apply(0);
    chk("idle_en", 512'(out_en), 512'(0));

    // mixed patterns: 0, 1 or 2 flips per lane
    for (int v = 0; v < 24; v++) begin
      for (int l = 0; l < L; l++) begin
        stimData[l] = {$urandom, $urandom};
        stimMask[l] = '0;
        ln = $urandom_range(0, 2);
        b1 = $urandom_range(0, 70);
        b2 = (b1 + $urandom_range(1, 70)) % 71;
        if (ln >= 1) stimMask[l][b1] = 1'b1;
        if (ln == 2) stimMask[l][b2] = 1'b1;
      end
      apply(1);
      if (v % 5 == 0) apply(0);
    end

    clearStim();
    doReset();
    for (int k = 0; k < 4; k++) begin
      stimData[1] = 64'h1111_2222_3333_4444 + 64'(k);
      stimMask[1] = '0; stimMask[1][10 + 13*k] = 1'b1;
      apply(1);
      chk("t6_cnt2", 512'(err_cnt2), 512'((k < 3) ? k + 1 : 3));
    end

    @(negedge clk); #1; rst = 1; in_en = 1;
    in_data[71*1 +: 71] = encode(64'h1) ^ 71'h4;
    @(posedge clk); #1;
    chk("rstwin_en", 512'({out_en, out_en2}), 512'(0));
    chk("rstwin_data", out_data, '0);
    chk("rstwin_flags", 512'({out_corr, out_unc, out_corr2, out_unc2}), 512'(0));
    chk("rstwin_cnt", 512'({err_cnt, err_cnt2}), 512'(0));
    rst = 0; in_en = 0;
    @(negedge clk);
    chkOn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
